inst_fetch_unit: RTL

Upstream neighbour of the ROM: generates sequential word addresses from a PC, drives the ROM read port and buffers the returned words. Presents each word with its PC to decode over a valid/ready handshake. Supports single-cycle redirect (branch/exception) with flush of buffered and in-flight words. Boot fetch starts at 0xbfc00000.

---
 rtl/inst_fetch_unit.sv | 89 ++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: walks the PC through the ROM read port, buffers returned words
// in a small FIFO and presents them with their PC to decode over valid/ready.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'hbfc00000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_en,
    output logic        rom_write_en,
    output logic [31:0] rom_addr,
    output logic [31:0] rom_write_data,
    input  logic [31:0] rom_read_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      pc;
    logic [31:0]      inflight_pc;
    logic             inflight;
    logic [31:0]      pc_mem   [BUF_DEPTH];
    logic [31:0]      data_mem [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] pending;
    logic             push;
    logic             pop;

    assign rom_write_en   = 1'b0;
    assign rom_write_data = 32'h0;
    assign rom_addr       = {pc[31:2], 2'b00};

    // Outputs are forced quiet while reset is asserted, not only after it.
    assign inst_valid = !rst && (count != '0);
    assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : 32'h0;
    assign inst_data  = inst_valid ? data_mem[rd_ptr] : 32'h0;

    assign pop  = inst_valid && inst_ready && !redirect_valid;
    // inflight is only ever set by an issue, and issue is blocked during a redirect
    // or reset, so a response following either is dropped for free.
    assign push = inflight && !redirect_valid && !rst;

    // Words owed to the FIFO once this cycle's pop is accounted for.
    assign pending = count + CNT_W'(inflight) - CNT_W'(inst_valid && inst_ready);
    assign rom_en  = !rst && !redirect_valid && (pending < CNT_W'(BUF_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            inflight <= rom_en;
            if (rom_en) begin
                inflight_pc <= pc;
                pc          <= pc + 32'd4;
            end
            if (redirect_valid) begin
                pc     <= {redirect_pc[31:2], 2'b00};
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= inflight_pc;
            data_mem[wr_ptr] <= rom_read_data;
        end
    end

endmodule
